// File: rtl/expedidor_duzias.sv
// Dozen stock holder: loads a saturated count and ships one dozen per REQ/ACK handshake.
// Optional sticky ERRO output is enabled by defining EXPEDIDOR_ERRO_EN.
module expedidor_duzias #(
  parameter int WIDTH       = 4,
  parameter int MAX_DUZIAS  = 10,
  parameter int SHIP_CYCLES = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] STOCK_IN,
  input  logic             REQ,
  output logic [WIDTH-1:0] COUNT,
  output logic             BUSY,
  output logic             ACK,
  output logic             EMPTY
`ifdef EXPEDIDOR_ERRO_EN
  ,
  output logic             ERRO
`endif
);

  localparam int TW = (SHIP_CYCLES > 1) ? $clog2(SHIP_CYCLES) : 1;
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_DUZIAS);
  localparam logic [TW-1:0]    TIMER_W = TW'(SHIP_CYCLES - 1);

  typedef enum logic {
    IDLE,
    SHIP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             over_max;

  assign over_max = (STOCK_IN > MAX_W);

  // NOTE: every next-state signal gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (LOAD) begin
          count_d = over_max ? MAX_W : STOCK_IN;
        end else if (REQ && (count_q != '0)) begin
          state_d = SHIP;
          timer_d = TIMER_W;
          busy_d  = 1'b1;
        end
      end
      SHIP: begin
        // LOAD and REQ are deliberately not looked at while the conveyor is held.
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          count_d = count_q - WIDTH'(1);
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // from the same pre-edge values.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign COUNT = count_q;
  assign BUSY  = busy_q;
  assign ACK   = ack_q;
  assign EMPTY = (count_q == '0);

`ifdef EXPEDIDOR_ERRO_EN
  logic erro_q, erro_d;

  // Out-of-range loads flag an error even when the load itself is not taken.
  assign erro_d = erro_q
                | ((state_q == IDLE) && REQ && !LOAD && (count_q == '0))
                | (LOAD && over_max);

  always_ff @(posedge CLOCK) begin
    if (RESET) erro_q <= 1'b0;
    else       erro_q <= erro_d;
  end

  assign ERRO = erro_q;
`endif

endmodule

// File: tb/tb_expedidor_duzias.sv
// Self-checking bench for expedidor_duzias: directed scenarios plus random
// traffic compared against a shipment-timestamp reference model.
module tb_expedidor_duzias;

  localparam int WIDTH       = 4;
  localparam int MAX_DUZIAS  = 10;
  localparam int SHIP_CYCLES = 4;

  logic             CLOCK = 1'b0;
  logic             RESET = 1'b1;
  logic             LOAD  = 1'b0;
  logic [WIDTH-1:0] STOCK_IN = '0;
  logic             REQ   = 1'b0;
  logic [WIDTH-1:0] COUNT;
  logic             BUSY;
  logic             ACK;
  logic             EMPTY;
`ifdef EXPEDIDOR_ERRO_EN
  logic             ERRO;
`endif

  expedidor_duzias #(
    .WIDTH      (WIDTH),
    .MAX_DUZIAS (MAX_DUZIAS),
    .SHIP_CYCLES(SHIP_CYCLES)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .LOAD    (LOAD),
    .STOCK_IN(STOCK_IN),
    .REQ     (REQ),
    .COUNT   (COUNT),
    .BUSY    (BUSY),
    .ACK     (ACK),
    .EMPTY   (EMPTY)
`ifdef EXPEDIDOR_ERRO_EN
    ,
    .ERRO    (ERRO)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  int checks   = 0;
  int failures = 0;

  // Reference model: stock as an integer, a shipment as "finishes at edge N".
  int edge_n   = 0;
  int m_stock  = 0;
  bit m_ship   = 0;
  int m_done   = 0;
  bit m_ack    = 0;
  bit m_erro   = 0;
  int ack_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit ld, input int si, input bit rq);
    edge_n++;
    if (rst) begin
      m_stock = 0; m_ship = 0; m_ack = 0; m_erro = 0;
      return;
    end
    if ((!m_ship && rq && !ld && m_stock == 0) || (ld && si > MAX_DUZIAS)) m_erro = 1;
    m_ack = 0;
    if (m_ship) begin
      if (edge_n == m_done) begin
        m_stock = m_stock - 1;
        m_ack   = 1;
        m_ship  = 0;
      end
    end else if (ld) begin
      m_stock = (si > MAX_DUZIAS) ? MAX_DUZIAS : si;
    end else if (rq && m_stock > 0) begin
      m_ship = 1;
      m_done = edge_n + SHIP_CYCLES;
    end
  endtask

  task automatic step(input bit rst, input bit ld, input int si, input bit rq);
    RESET    = rst;
    LOAD     = ld;
    STOCK_IN = WIDTH'(si);
    REQ      = rq;
    @(posedge CLOCK);
    model_edge(rst, ld, si, rq);
    #1;
    if (ACK === 1'b1) ack_seen++;
    check("count", 32'(COUNT), 32'(m_stock));
    check("busy",  32'(BUSY),  32'(m_ship));
    check("ack",   32'(ACK),   32'(m_ack));
    check("empty", 32'(EMPTY), 32'(m_stock == 0));
`ifdef EXPEDIDOR_ERRO_EN
    check("erro",  32'(ERRO),  32'(m_erro));
`endif
  endtask

  initial begin
    // Reset for two cycles, then REQ on an empty stock must do nothing.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("reset_count", 32'(COUNT), 32'd0);
    check("reset_empty", 32'(EMPTY), 32'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    check("empty_req_busy", 32'(BUSY), 32'd0);

    // Load 3 and hold REQ: exactly three shipments, empty with the last ACK.
    step(0, 1, 3, 0);
    ack_seen = 0;
    for (int i = 0; i < 25; i++) begin
      step(0, 0, 0, 1);
      if (ACK === 1'b1 && ack_seen == 3) check("empty_with_3rd_ack", 32'(EMPTY), 32'd1);
    end
    check("three_acks", 32'(ack_seen), 32'd3);
    check("drained", 32'(COUNT), 32'd0);

    // Over-range load saturates.
    step(0, 1, 15, 0);
    check("saturate", 32'(COUNT), 32'(MAX_DUZIAS));
    step(0, 0, 0, 0);

    // Load during SHIP is ignored.
    step(0, 1, 5, 0);
    step(0, 0, 0, 1);
    step(0, 1, 9, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("load_in_ship", 32'(COUNT), 32'd4);

    // LOAD and REQ together: load wins, REQ accepted on the following edge.
    step(0, 1, 2, 1);
    check("load_req_nobusy", 32'(BUSY), 32'd0);
    step(0, 0, 0, 1);
    check("req_after_load", 32'(BUSY), 32'd1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Reset in the middle of a shipment aborts it.
    step(0, 1, 6, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("abort_count", 32'(COUNT), 32'd0);
    check("abort_ack",   32'(ACK),   32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 4) == 0),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
